uart_word_assembler: RTL and testbench

UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

---
 rtl/uart_word_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/uart_word_assembler.sv | 93 +++++++++
 tb/tb_uart_word_assembler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_pkg.sv
// ---------------------------------------------------------------------------
// uart_word_pkg
// Shared types and width constants for the UART word assembler slice.
//   rx_state_t      : byte receiver FSM states
//   BYTE_W / WORD_W : widths of a received byte and an assembled word
//   SHADOW_W        : bytes 0-2 of a word waiting for the final byte
// ---------------------------------------------------------------------------
package uart_word_pkg;

   localparam int BYTE_W   = 8;
   localparam int WORD_W   = 32;
   localparam int SHADOW_W = WORD_W - BYTE_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver, LSB first.
//   clock       : system clock, rising edge
//   reset       : asynchronous active-low reset
//   rx          : raw asynchronous UART line, idle high
//   data        : last received byte (valid while byte_strobe is high)
//   byte_strobe : one-cycle pulse, stop bit sampled high
//   frame_error : one-cycle pulse, stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_byte
   import uart_word_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   output logic [BYTE_W-1:0] data,
   output logic              byte_strobe,
   output logic              frame_error
);

   localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

   rx_state_t   state;
   logic        rx_meta;
   logic        rx_sync;
   logic        rx_prev;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic        stop_sample;

   // Two-flop synchronizer plus a delayed copy for start-edge detection.
   // All three idle high so that reset release never looks like a start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver FSM. The start bit is re-checked at its midpoint so that short
   // low glitches fall back to IDLE; every later sample is one full bit
   // period after the previous one, which keeps all samples mid-bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (rx_prev && !rx_sync) begin
                  state <= START;
               end
            end
            START: begin
               if (baud_cnt == HALF_CNT) begin
                  baud_cnt <= '0;
                  state    <= rx_sync ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_cnt == FULL_CNT) begin
                  baud_cnt      <= '0;
                  data[bit_idx] <= rx_sync;
                  bit_idx       <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_cnt == FULL_CNT) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The stop-bit verdict is decoded straight from registered state so the
   // word register above can capture it on the very sampling edge.
   assign stop_sample = (state == STOP) && (baud_cnt == FULL_CNT);
   assign byte_strobe = stop_sample && rx_sync;
   assign frame_error = stop_sample && !rx_sync;

endmodule

// File: rtl/uart_word_assembler.sv
// ---------------------------------------------------------------------------
// uart_word_assembler
// Collects four UART bytes (MSB first) into a 32-bit display word.
//   clock       : system clock, rising edge
//   reset       : asynchronous active-low reset
//   rx          : raw asynchronous UART line, idle high, 8N1
//   word        : last complete word, feeds the display driver BCD_in
//   word_valid  : one-cycle pulse in the cycle word updates
//   frame_error : one-cycle pulse when a stop bit samples low
//   byte_count  : bytes held of the current partial word, 0-3
// ---------------------------------------------------------------------------
module uart_word_assembler
   import uart_word_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_CLKS = 868000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   output logic [WORD_W-1:0] word,
   output logic              word_valid,
   output logic              frame_error,
   output logic [1:0]        byte_count
);

   localparam int            TO_W    = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

   logic [BYTE_W-1:0]   rx_data;
   logic                rx_strobe;
   logic                rx_frame_error;
   logic [SHADOW_W-1:0] shadow;
   logic [TO_W-1:0]     timeout_cnt;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clock       (clock),
      .reset       (reset),
      .rx          (rx),
      .data        (rx_data),
      .byte_strobe (rx_strobe),
      .frame_error (rx_frame_error)
   );

   // Word assembly. A byte strobe has priority over the timeout, so a byte
   // landing on the last timeout clock still counts. Frame errors and
   // timeouts only drop the partial word; the displayed word is untouched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word        <= '0;
         word_valid  <= 1'b0;
         frame_error <= 1'b0;
         byte_count  <= '0;
         shadow      <= '0;
         timeout_cnt <= '0;
      end else begin
         word_valid  <= 1'b0;
         frame_error <= 1'b0;
         if (rx_strobe) begin
            timeout_cnt <= '0;
            case (byte_count)
               2'd0: shadow[23:16] <= rx_data;
               2'd1: shadow[15:8]  <= rx_data;
               2'd2: shadow[7:0]   <= rx_data;
               default: begin
                  word       <= {shadow, rx_data};
                  word_valid <= 1'b1;
                  shadow     <= '0;
               end
            endcase
            byte_count <= byte_count + 2'd1;
         end else if (rx_frame_error) begin
            frame_error <= 1'b1;
            byte_count  <= '0;
            shadow      <= '0;
            timeout_cnt <= '0;
         end else if (byte_count != 2'd0) begin
            if (timeout_cnt == TO_LAST) begin
               byte_count  <= '0;
               shadow      <= '0;
               timeout_cnt <= '0;
            end else begin
               timeout_cnt <= timeout_cnt + 1'b1;
            end
         end else begin
            timeout_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_word_assembler
// Self-checking bench for uart_word_assembler with CLKS_PER_BIT=16 and
// TIMEOUT_CLKS=2000. Directed scenarios plus a randomized byte stream
// checked against a byte-list model of word assembly.
// ---------------------------------------------------------------------------
module tb_uart_word_assembler;

   localparam int CPB     = 16;
   localparam int TIMEOUT = 2000;

   logic        clock;
   logic        reset;
   logic        rx;
   logic [31:0] word;
   logic        word_valid;
   logic        frame_error;
   logic [1:0]  byte_count;

   int checks   = 0;
   int failures = 0;

   int          wv_pulses = 0;
   int          fe_pulses = 0;
   logic [31:0] got_words[$];
   logic [31:0] prev_word = '0;

   uart_word_assembler #(
      .CLKS_PER_BIT (CPB),
      .TIMEOUT_CLKS (TIMEOUT)
   ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .rx          (rx),
      .word        (word),
      .word_valid  (word_valid),
      .frame_error (frame_error),
      .byte_count  (byte_count)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse monitor, sampled on the falling edge away from DUT updates.
   // Records completed words and checks pulse exclusivity and word stability.
   always @(negedge clock) begin
      if (word_valid) begin
         wv_pulses++;
         got_words.push_back(word);
      end
      if (frame_error) fe_pulses++;
      if (word_valid || frame_error) begin
         checks++;
         if (word_valid && frame_error) begin
            failures++;
            $display("[TB] FAIL pulse_exclusive: word_valid=%b frame_error=%b required not both", word_valid, frame_error);
         end
      end
      if (reset && !word_valid) begin
         checks++;
         if (word !== prev_word) begin
            failures++;
            $display("[TB] FAIL word_stable: word=%h changed from %h without word_valid", word, prev_word);
         end
      end
      prev_word = word;
   end

   // Drives one 8N1 frame; stop_bit=0 forces a framing error.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (word !== 32'h0 || word_valid !== 1'b0 || frame_error !== 1'b0 || byte_count !== 2'd0) begin
         failures++;
         $display("[TB] FAIL reset_state: word=%h wv=%b fe=%b bc=%0d required all zero", word, word_valid, frame_error, byte_count);
      end
      reset = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_single_word();
      logic [7:0] bytes[4];
      logic [1:0] exp_bc;
      int wv0;
      bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
      wv0 = wv_pulses;
      for (int i = 0; i < 4; i++) begin
         send_byte(bytes[i], 1'b1);
         exp_bc = 2'((i + 1) % 4);
         checks++;
         if (byte_count !== exp_bc) begin
            failures++;
            $display("[TB] FAIL single_bc[%0d]: byte_count=%0d required %0d", i, byte_count, exp_bc);
         end
      end
      checks++;
      if (wv_pulses - wv0 !== 1 || word !== 32'h12345678) begin
         failures++;
         $display("[TB] FAIL single_word: pulses=%0d word=%h required 1 pulse word=12345678", wv_pulses - wv0, word);
      end
   endtask

   task automatic test_timeout();
      int wv0;
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      repeat (1900) @(negedge clock);
      checks++;
      if (byte_count !== 2'd2) begin
         failures++;
         $display("[TB] FAIL timeout_early: byte_count=%0d required 2", byte_count);
      end
      repeat (200) @(negedge clock);
      checks++;
      if (byte_count !== 2'd0 || word !== 32'h12345678) begin
         failures++;
         $display("[TB] FAIL timeout_clear: byte_count=%0d word=%h required 0 and 12345678", byte_count, word);
      end
      wv0 = wv_pulses;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
      checks++;
      if (wv_pulses - wv0 !== 1 || word !== 32'hAABBCCDD) begin
         failures++;
         $display("[TB] FAIL timeout_word: pulses=%0d word=%h required 1 pulse word=AABBCCDD", wv_pulses - wv0, word);
      end
   endtask

   task automatic test_frame_error();
      int wv0, fe0;
      send_byte(8'h77, 1'b1);
      wv0 = wv_pulses;
      fe0 = fe_pulses;
      send_byte(8'h55, 1'b0);
      checks++;
      if (fe_pulses - fe0 !== 1) begin
         failures++;
         $display("[TB] FAIL frame_error_pulse: high cycles=%0d required 1", fe_pulses - fe0);
      end
      checks++;
      if (byte_count !== 2'd0 || word !== 32'hAABBCCDD || wv_pulses != wv0) begin
         failures++;
         $display("[TB] FAIL frame_error_state: bc=%0d word=%h required 0 and AABBCCDD", byte_count, word);
      end
   endtask

   task automatic test_glitch();
      int wv0, fe0;
      send_byte(8'h11, 1'b1);
      wv0 = wv_pulses;
      fe0 = fe_pulses;
      rx = 1'b0;
      repeat (5) @(negedge clock);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      checks++;
      if (byte_count !== 2'd1 || wv_pulses != wv0 || fe_pulses != fe0) begin
         failures++;
         $display("[TB] FAIL glitch: bc=%0d wv=%0d fe=%0d required bc=1 and no pulses", byte_count, wv_pulses - wv0, fe_pulses - fe0);
      end
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      checks++;
      if (word !== 32'h11223344) begin
         failures++;
         $display("[TB] FAIL glitch_resync: word=%h required 11223344", word);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes[8];
      int wv0;
      bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      got_words.delete();
      wv0 = wv_pulses;
      for (int i = 0; i < 8; i++) begin
         send_byte(bytes[i], 1'b1);
         if (i >= 3 && i <= 6) begin
            checks++;
            if (word !== 32'h01020304) begin
               failures++;
               $display("[TB] FAIL b2b_hold[%0d]: word=%h required 01020304", i, word);
            end
         end
      end
      checks++;
      if (wv_pulses - wv0 !== 2 || got_words.size() != 2) begin
         failures++;
         $display("[TB] FAIL b2b_pulses: pulses=%0d required 2", wv_pulses - wv0);
      end else begin
         checks++;
         if (got_words[0] !== 32'h01020304 || got_words[1] !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL b2b_words: got %h,%h required 01020304,FFFFFFFF", got_words[0], got_words[1]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b3;
      logic [7:0] bytes[4];
      int wv0;
      b3 = 8'h5A;
      send_byte(8'hCA, 1'b1);
      send_byte(8'hFE, 1'b1);
      send_byte(8'hBA, 1'b1);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         rx = b3[i];
         repeat (CPB) @(negedge clock);
      end
      rx = b3[4];
      repeat (CPB / 2) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (word !== 32'h0 || byte_count !== 2'd0 || word_valid !== 1'b0 || frame_error !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_async: word=%h bc=%0d wv=%b fe=%b required all zero", word, byte_count, word_valid, frame_error);
      end
      rx = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      wv0 = wv_pulses;
      for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1);
      checks++;
      if (wv_pulses - wv0 !== 1 || word !== 32'hDEADBEEF) begin
         failures++;
         $display("[TB] FAIL reset_resume: pulses=%0d word=%h required 1 pulse DEADBEEF", wv_pulses - wv0, word);
      end
   endtask

   // Random byte stream. The model keeps the pending bytes of the current
   // word in a queue: a bad stop bit or an idle gap past the timeout empties
   // it, and every fourth good byte turns it into an expected word.
   task automatic test_random();
      logic [7:0]  pending[$];
      logic [31:0] exp_words[$];
      logic [7:0]  b;
      logic        good;
      int          gap;
      int          n;
      got_words.delete();
      for (int i = 0; i < 28; i++) begin
         b    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 7) != 0);
         send_byte(b, good);
         if (!good) begin
            pending.delete();
         end else begin
            pending.push_back(b);
            if (pending.size() == 4) begin
               exp_words.push_back({pending[0], pending[1], pending[2], pending[3]});
               pending.delete();
            end
         end
         checks++;
         if (byte_count !== 2'(pending.size())) begin
            failures++;
            $display("[TB] FAIL rand_bc[%0d]: byte_count=%0d required %0d", i, byte_count, pending.size());
         end
         gap = ($urandom_range(0, 5) == 0) ? 2100 : $urandom_range(0, 20);
         repeat (gap) @(negedge clock);
         if (gap > TIMEOUT) pending.delete();
      end
      checks++;
      if (got_words.size() != exp_words.size()) begin
         failures++;
         $display("[TB] FAIL rand_count: words=%0d required %0d", got_words.size(), exp_words.size());
      end else begin
         n = exp_words.size();
         for (int k = 0; k < n; k++) begin
            checks++;
            if (got_words[k] !== exp_words[k]) begin
               failures++;
               $display("[TB] FAIL rand_word[%0d]: word=%h required %h", k, got_words[k], exp_words[k]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      rx    = 1'b1;
      test_reset();
      test_single_word();
      test_timeout();
      test_frame_error();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
